// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32I immediate encoder.
// Immediate-format encodings match the sign_extend case labels.
package imm_encoder_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [DATA_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

    // One encoded word as it travels through the skid buffer
    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] instr;
    } enc_word_t;

endpackage

// File: rtl/imm_encoder_imm_pack.sv
// Combinational packer: fields + immediate -> {err, instr}.
// Out-of-range immediates or unknown formats produce a NOP with err set.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [2:0]            imm_src,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    output enc_word_t             word_c
);

    logic is_ok;
    logic [DATA_WIDTH-1:0] raw;
    logic ext11_ok;
    logic ext12_ok;
    logic ext20_ok;

    // Upper bits must be pure sign extension for the field to represent imm
    assign ext11_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign ext12_ok = (&imm[31:12]) | ~(|imm[31:12]);
    assign ext20_ok = (&imm[31:20]) | ~(|imm[31:20]);

    // Format selection and range check
    always_comb begin
        raw   = '0;
        is_ok = 1'b0;
        unique case (imm_src)
            IMM_I: begin
                raw   = {imm[11:0], rs1, funct3, rd, opcode};
                is_ok = ext11_ok;
            end
            IMM_S: begin
                raw   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                is_ok = ext11_ok;
            end
            IMM_B: begin
                raw   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                is_ok = ext12_ok & ~imm[0];
            end
            IMM_J: begin
                raw   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                is_ok = ext20_ok & ~imm[0];
            end
            IMM_U: begin
                raw   = {imm[31:12], rd, opcode};
                is_ok = ~(|imm[11:0]);
            end
            default: begin
                raw   = '0;
                is_ok = 1'b0;
            end
        endcase
        word_c.err   = ~is_ok;
        word_c.instr = is_ok ? raw : INSTR_NOP;
    end

endmodule

// File: rtl/imm_encoder.sv
// Streaming RV32I instruction encoder with valid/ready handshake,
// output register plus one skid register, and an optional saturating
// error counter enabled by IMM_ENC_ERR_CNT_EN.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [2:0]            imm_src,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  out_err,
    output logic [ERR_CNT_W-1:0]  err_count
);

    enc_word_t new_word_c;
    enc_word_t out_q, out_n;
    enc_word_t skid_q, skid_n;
    logic      out_valid_q, out_valid_n;
    logic      skid_valid_q, skid_valid_n;
    logic      in_ready_q;
    logic      in_fire;
    logic      out_fire;

    imm_pack u_imm_pack (
        .imm     (imm),
        .imm_src (imm_src),
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct3  (funct3),
        .word_c  (new_word_c)
    );

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Skid-buffer next state: skid refills the output first, new words bypass when skid empty
    always_comb begin
        out_valid_n  = out_valid_q;
        out_n        = out_q;
        skid_valid_n = skid_valid_q;
        skid_n       = skid_q;
        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_valid_n  = 1'b1;
                out_n        = skid_q;
                skid_valid_n = 1'b0;
            end else if (in_fire) begin
                out_valid_n = 1'b1;
                out_n       = new_word_c;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_n = 1'b1;
            skid_n       = new_word_c;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_n;
            out_q        <= out_n;
            skid_valid_q <= skid_valid_n;
            skid_q       <= skid_n;
            in_ready_q   <= ~skid_valid_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign instr     = out_q.instr;
    assign out_err   = out_q.err;

`ifdef IMM_ENC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating count of errored words leaving the output
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (out_fire && out_q.err && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule
